mux4_rr_sel_ctrl: RTL and testbench

//  - Upstream control stage for the 4:1 one-bit/WIDTH-bit mux: arbitrates four request lines,

---
 rtl/mux4_rr_sel_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_mux4_rr_sel_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_sel_ctrl.sv
// mux4_rr_sel_ctrl
// Arbitrates four request lines and drives the select of an external
// combinational 4:1 mux. The mux output is captured into a registered
// valid/ready stream.
//
// A transfer takes three states:
//   IDLE - no transfer in progress.
//   SEL  - sel is stable for one cycle so the external mux can settle.
//   CAP  - out_data is presented on the stream until the consumer accepts it.
//
// Configuration macro: MUX4_SEL_FIXED_PRIO_EN
//   defined   : fixed priority. The lowest-index request wins and ptr stays 0.
//   undefined : round-robin (default). Scanning starts at ptr, and ptr moves
//               to the channel after the one just served.
module mux4_rr_sel_ctrl #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  output logic [1:0]       sel,
  input  logic [WIDTH-1:0] mux_out,
  output logic [3:0]       ack,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_ch,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    CAP  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       ptr;
  logic [1:0]       ptr_nxt;
  logic [1:0]       sel_nxt;
  logic [3:0]       ack_nxt;
  logic [WIDTH-1:0] out_data_nxt;
  logic [1:0]       out_ch_nxt;
  logic             out_valid_nxt;
  logic             busy_nxt;
  logic [1:0]       winner;
  logic             any_req;

  // Round-robin pick: the first set request found when scanning p, p+1, ... mod 4.
  function automatic logic [1:0] pick_rr(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] res;
    logic       found;
    res   = p;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = p + 2'(i);
      if (!found && r[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Fixed-priority pick: the lowest-index set request.
  function automatic logic [1:0] pick_fixed(input logic [3:0] r);
    logic [1:0] res;
    if (r[0]) begin
      res = 2'd0;
    end else if (r[1]) begin
      res = 2'd1;
    end else if (r[2]) begin
      res = 2'd2;
    end else begin
      res = 2'd3;
    end
    return res;
  endfunction

  assign any_req = |req;

`ifdef MUX4_SEL_FIXED_PRIO_EN
  assign winner = pick_fixed(req);
`else
  assign winner = pick_rr(req, ptr);
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. CAP moves straight to SEL when a new request is
  // pending, so back-to-back transfers have no IDLE bubble.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = SEL;
        end else begin
          state_nxt = IDLE;
        end
      end
      SEL: begin
        state_nxt = CAP;
      end
      CAP: begin
        if (out_ready) begin
          if (any_req) begin
            state_nxt = SEL;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          state_nxt = CAP;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output logic. This computes the next value of every registered output.
  // Registers hold by default, and ack defaults to 0 so it only pulses.
  always_comb begin
    sel_nxt       = sel;
    ack_nxt       = 4'b0000;
    out_data_nxt  = out_data;
    out_ch_nxt    = out_ch;
    out_valid_nxt = out_valid;
    ptr_nxt       = ptr;
    busy_nxt      = (state_nxt != IDLE);
    case (state)
      IDLE: begin
        if (any_req) begin
          sel_nxt = winner;
        end else begin
          sel_nxt = sel;
        end
      end
      SEL: begin
        // Capture happens even if the request was withdrawn during SEL.
        out_data_nxt  = mux_out;
        out_ch_nxt    = sel;
        out_valid_nxt = 1'b1;
        ack_nxt       = 4'b0001 << sel;
`ifdef MUX4_SEL_FIXED_PRIO_EN
        ptr_nxt       = 2'd0;
`else
        ptr_nxt       = sel + 2'd1;
`endif
      end
      CAP: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          if (any_req) begin
            sel_nxt = winner;
          end else begin
            sel_nxt = sel;
          end
        end else begin
          out_valid_nxt = 1'b1;
        end
      end
      default: begin
        out_valid_nxt = 1'b0;
      end
    endcase
  end

  // Output and pointer registers. Reset clears them asynchronously, so any
  // capture in flight is dropped without issuing an ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel       <= 2'd0;
      ack       <= 4'b0000;
      out_data  <= '0;
      out_ch    <= 2'd0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      ptr       <= 2'd0;
    end else begin
      sel       <= sel_nxt;
      ack       <= ack_nxt;
      out_data  <= out_data_nxt;
      out_ch    <= out_ch_nxt;
      out_valid <= out_valid_nxt;
      busy      <= busy_nxt;
      ptr       <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_mux4_rr_sel_ctrl.sv
// tb_mux4_rr_sel_ctrl
// Directed bench for mux4_rr_sel_ctrl (WIDTH=1).
// The external 4:1 mux is modelled as mux_out = mux_in[sel].
// The cycle table is written for the default round-robin build.
// The hand-written sequences also cover MUX4_SEL_FIXED_PRIO_EN.
module tb_mux4_rr_sel_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [1:0] sel;
  logic [0:0] mux_out;
  logic [3:0] ack;
  logic [0:0] out_data;
  logic [1:0] out_ch;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic [3:0] mux_in;

  int checks = 0;
  int errors = 0;

  mux4_rr_sel_ctrl #(.WIDTH(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .sel       (sel),
    .mux_out   (mux_out),
    .ack       (ack),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  assign mux_out = mux_in[sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] mi;
    logic       rdy;
    logic [1:0] sel;
    logic [3:0] ack;
    logic       data;
    logic [1:0] ch;
    logic       valid;
    logic       busy;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] e_sel, input logic [3:0] e_ack,
                         input logic e_data, input logic [1:0] e_ch, input logic e_valid,
                         input logic e_busy);
    chk({tag, " sel"},   32'(sel),       32'(e_sel));
    chk({tag, " ack"},   32'(ack),       32'(e_ack));
    chk({tag, " data"},  32'(out_data),  32'(e_data));
    chk({tag, " ch"},    32'(out_ch),    32'(e_ch));
    chk({tag, " valid"}, 32'(out_valid), 32'(e_valid));
    chk({tag, " busy"},  32'(busy),      32'(e_busy));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_ch;
    logic [3:0] mi_v;
    int         ack_cnt;

    rst       = 1'b1;
    req       = 4'b0000;
    mux_in    = 4'b0000;
    out_ready = 1'b0;

    // Fields: rst, req, mux_in, out_ready | sel, ack, data, ch, valid, busy
    // Each row gives the values expected just after the next rising edge.
    vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0}; // reset
    vecs[1]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0}; // idle, no req
    vecs[2]  = '{1'b0, 4'b0100, 4'b0100, 1'b1, 2'd2, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b1}; // SEL ch2
    vecs[3]  = '{1'b0, 4'b0100, 4'b0100, 1'b1, 2'd2, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b1}; // capture ch2
    vecs[4]  = '{1'b0, 4'b0000, 4'b0100, 1'b1, 2'd2, 4'b0000, 1'b1, 2'd2, 1'b0, 1'b0}; // accepted -> IDLE
    vecs[5]  = '{1'b0, 4'b1001, 4'b1000, 1'b1, 2'd3, 4'b0000, 1'b1, 2'd2, 1'b0, 1'b1}; // ptr=3 -> ch3
    vecs[6]  = '{1'b0, 4'b1001, 4'b1000, 1'b1, 2'd3, 4'b1000, 1'b1, 2'd3, 1'b1, 1'b1}; // capture ch3
    vecs[7]  = '{1'b0, 4'b0001, 4'b0001, 1'b1, 2'd0, 4'b0000, 1'b1, 2'd3, 1'b0, 1'b1}; // wrap -> ch0
    vecs[8]  = '{1'b0, 4'b0001, 4'b0000, 1'b1, 2'd0, 4'b0001, 1'b0, 2'd0, 1'b1, 1'b1}; // capture ch0
    vecs[9]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b1}; // hold in CAP
    vecs[10] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 2'd0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0}; // accepted -> IDLE
    vecs[11] = '{1'b0, 4'b0010, 4'b0010, 1'b1, 2'd1, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b1}; // SEL ch1
    vecs[12] = '{1'b0, 4'b0000, 4'b0010, 1'b1, 2'd1, 4'b0010, 1'b1, 2'd1, 1'b1, 1'b1}; // req dropped, still captured
    vecs[13] = '{1'b0, 4'b0000, 4'b0010, 1'b1, 2'd1, 4'b0000, 1'b1, 2'd1, 1'b0, 1'b0}; // -> IDLE, busy 0
    vecs[14] = '{1'b0, 4'b0000, 4'b0010, 1'b1, 2'd1, 4'b0000, 1'b1, 2'd1, 1'b0, 1'b0}; // ready w/o valid ignored

`ifndef MUX4_SEL_FIXED_PRIO_EN
    for (int i = 0; i < 15; i++) begin
      rst       = vecs[i].rst;
      req       = vecs[i].req;
      mux_in    = vecs[i].mi;
      out_ready = vecs[i].rdy;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].sel, vecs[i].ack, vecs[i].data,
              vecs[i].ch, vecs[i].valid, vecs[i].busy);
    end
`endif

    // Round robin with all four requests held: served 0,1,2,3,0, one transfer per 2 cycles.
    rst = 1'b1;
    req = 4'b0000;
    step();
    chk_all("rr reset", 2'd0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    rst       = 1'b0;
    req       = 4'b1111;
    mux_in    = 4'b1010;
    out_ready = 1'b1;
    mi_v      = mux_in;
    for (int k = 0; k < 5; k++) begin
`ifdef MUX4_SEL_FIXED_PRIO_EN
      exp_ch = 2'd0;
`else
      exp_ch = 2'(k % 4);
`endif
      step();
      chk($sformatf("rr%0d sel", k),       32'(sel),       32'(exp_ch));
      chk($sformatf("rr%0d sel_valid", k), 32'(out_valid), 32'd0);
      step();
      chk($sformatf("rr%0d ch", k),        32'(out_ch),    32'(exp_ch));
      chk($sformatf("rr%0d valid", k),     32'(out_valid), 32'd1);
      chk($sformatf("rr%0d ack", k),       32'(ack),       32'(4'b0001 << exp_ch));
      chk($sformatf("rr%0d data", k),      32'(out_data),  32'(mi_v[exp_ch]));
    end
    req = 4'b0000;
    step();
    chk("rr end busy", 32'(busy), 32'd0);

    // Backpressure: out_ready low for 5 cycles while mux_out toggles.
    req       = 4'b0100;
    mux_in    = 4'b0100;
    out_ready = 1'b0;
    ack_cnt   = 0;
    step();
    chk("bp sel", 32'(sel), 32'd2);
    step();
    if (ack != 4'b0000) ack_cnt++;
    chk("bp cap ack", 32'(ack), 32'(4'b0100));
    req = 4'b0000;
    for (int c = 0; c < 5; c++) begin
      mux_in = ~mux_in;
      step();
      if (ack != 4'b0000) ack_cnt++;
      chk($sformatf("bp%0d data", c),  32'(out_data),  32'd1);
      chk($sformatf("bp%0d ch", c),    32'(out_ch),    32'd2);
      chk($sformatf("bp%0d sel", c),   32'(sel),       32'd2);
      chk($sformatf("bp%0d valid", c), 32'(out_valid), 32'd1);
    end
    chk("bp ack count", 32'(ack_cnt), 32'd1);
    out_ready = 1'b1;
    step();
    chk("bp accept valid", 32'(out_valid), 32'd0);
    chk("bp accept busy",  32'(busy),      32'd0);
    step();
    chk("bp once valid", 32'(out_valid), 32'd0);
    chk("bp once ack",   32'(ack),       32'(4'b0000));

    // Asynchronous reset asserted mid-CAP clears outputs before the next edge.
    req       = 4'b0001;
    mux_in    = 4'b0001;
    out_ready = 1'b0;
    step();
    step();
    chk("ar pre valid", 32'(out_valid), 32'd1);
    chk("ar pre data",  32'(out_data),  32'd1);
    req = 4'b0000;
    #2;
    rst = 1'b1;
    #1;
    chk_all("ar async", 2'd0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    step();
    chk_all("ar after", 2'd0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
